// File: rtl/seq_multiplier_32x32_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_multiplier_32x32_pkg
// Purpose : Shared definitions for the iterative shift-add multiplier.
//           - Controller state encoding (2 bits).
//           - Iteration counter width helper, $clog2(WIDTH+1).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package seq_multiplier_32x32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Counter is wide enough to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_multiplier_32x32_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seq_multiplier_32x32_ctrl
// Purpose : Sequencing FSM and iteration counter of the shift-add multiplier.
//           IDLE -> CALC (WIDTH cycles) -> FIX -> DONE -> IDLE.
// Ports   : clk, rst_n         clock, asynchronous active-low reset
//           in_valid_i         operand pair offered
//           out_ready_i        consumer accepts the product
//           load_o             latch operands / clear accumulator (this edge)
//           step_o             perform one shift-add iteration (this edge)
//           fix_o              apply sign correction into product (this edge)
//           in_ready_o         high in IDLE only
//           out_valid_o        high in DONE only
//           busy_o             high in CALC, FIX and DONE
// Revision: 1.0 - initial release
// ============================================================================
module seq_multiplier_32x32_ctrl
  import seq_multiplier_32x32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid_i,
  input  logic out_ready_i,
  output logic load_o,
  output logic step_o,
  output logic fix_o,
  output logic in_ready_o,
  output logic out_valid_o,
  output logic busy_o
);

  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_o      = 1'b0;
    step_o      = 1'b0;
    fix_o       = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          load_o  = 1'b1;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        busy_o = 1'b1;
        step_o = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        // Fixed latency: the step taken with count==WIDTH-1 is the last one.
        if (cnt_q == LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        busy_o  = 1'b1;
        fix_o   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_multiplier_32x32.sv
`default_nettype none
// ============================================================================
// Module  : seq_multiplier_32x32
// Purpose : Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
//           one operation in flight, valid/ready handshake on both sides.
//           The product feeds the 64-bit product input of slicer_64x32.
// Params  : WIDTH  operand width (product is 2*WIDTH)
//           SIGNED 0: unsigned, 1: two's-complement operands and product
// Ports   : clk, rst_n                 clock, asynchronous active-low reset
//           in_valid / in_ready        operand handshake (ready in IDLE only)
//           multiplicand, multiplier   operands A and B
//           out_valid / out_ready      product handshake (held until accepted)
//           product                    A*B, kept after handshake until next FIX
//           busy                       high in CALC, FIX and DONE
// Revision: 1.0 - initial release
// ============================================================================
module seq_multiplier_32x32
  import seq_multiplier_32x32_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  logic w_load, w_step, w_fix;

  seq_multiplier_32x32_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .out_ready_i (out_ready),
    .load_o      (w_load),
    .step_o      (w_step),
    .fix_o       (w_fix),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .busy_o      (busy)
  );

  // Magnitudes and result sign. The most-negative operand negates to
  // 2^(WIDTH-1), which still fits WIDTH bits when read as unsigned.
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic             w_neg;

  always_comb begin
    w_abs_a = multiplicand;
    w_abs_b = multiplier;
    w_neg   = 1'b0;
    if (SIGNED != 0) begin
      if (multiplicand[WIDTH-1]) w_abs_a = ~multiplicand + WIDTH'(1);
      if (multiplier[WIDTH-1])   w_abs_b = ~multiplier   + WIDTH'(1);
      w_neg = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
    end
  end

  logic [2*WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0]   mplier_q,  mplier_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic               neg_q,     neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (w_load) begin
      mcand_d  = {{WIDTH{1'b0}}, w_abs_a};
      mplier_d = w_abs_b;
      acc_d    = '0;
      neg_d    = w_neg;
    end
    if (w_step) begin
      // LSB-first: add the multiplicand already aligned to this bit position.
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
    if (w_fix) begin
      product_d = neg_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier_32x32.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_multiplier_32x32
// Purpose : Self-checking bench for seq_multiplier_32x32 (unsigned and signed
//           instances) against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_multiplier_32x32;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid  [2];
  logic          out_ready [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic          busy      [2];
  logic [W-1:0]  mcand     [2];
  logic [W-1:0]  mplier    [2];
  logic [2*W-1:0] product  [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_multiplier_32x32 #(.WIDTH(W), .SIGNED(0)) u_mul_u (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .multiplicand(mcand[0]), .multiplier(mplier[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .product(product[0]), .busy(busy[0])
  );

  seq_multiplier_32x32 #(.WIDTH(W), .SIGNED(1)) u_mul_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .multiplicand(mcand[1]), .multiplier(mplier[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .product(product[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on full-width values.
  function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] ua, ub;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers one operand pair and returns after the accepting edge (lat=1).
  task automatic start_op(input int u, input logic [31:0] a, input logic [31:0] b, output int lat);
    int guard = 0;
    while (!in_ready[u] && guard < 60) begin
      tick;
      guard++;
    end
    if (!in_ready[u]) check("in_ready_timeout", 64'(in_ready[u]), 64'd1);
    in_valid[u] = 1'b1;
    mcand[u]    = a;
    mplier[u]   = b;
    tick;
    in_valid[u] = 1'b0;
    lat = 1;
  endtask

  // Counts edges (accept edge included) until out_valid is seen, bounded.
  task automatic wait_valid(input int u, inout int lat);
    while (!out_valid[u] && lat < 200) begin
      tick;
      lat++;
    end
  endtask

  task automatic do_mult(input int u, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat;
    out_ready[u] = 1'b1;
    start_op(u, a, b, lat);
    wait_valid(u, lat);
    check({tag, "_lat"}, 64'(lat), 64'(W + 2));
    check(tag, product[u], ref_mul(u == 1, a, b));
    tick;
    check({tag, "_idle"}, 64'(in_ready[u]), 64'd1);
  endtask

  initial begin
    int          lat;
    logic [63:0] held;
    logic [63:0] exp_q [$];
    logic [31:0] a6 [3];
    logic [31:0] b6 [3];
    int          sent, got, last_out, cyc;
    bit          acc;

    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; mcand[i] = '0; mplier[i] = '0;
    end

    // Reset state
    repeat (2) tick;
    check("rst_in_ready",  64'(in_ready[0]),  64'd1);
    check("rst_out_valid", 64'(out_valid[0]), 64'd0);
    check("rst_busy",      64'(busy[0]),      64'd0);
    check("rst_product",   product[0],        64'd0);
    check("rst_product_s", product[1],        64'd0);
    rst_n = 1'b1;
    tick;

    // Directed: unsigned corner operands
    do_mult(0, 32'h0000_0001, 32'hFFFF_FFFF, "t1");
    check("t1_const_held", product[0], 64'h0000_0000_FFFF_FFFF);
    do_mult(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2");
    held = product[0];
    check("t2_msb", {32'b0, held[63:32]}, 64'h0000_0000_FFFF_FFFE);
    check("t2_lsb", {32'b0, held[31:0]},  64'h0000_0000_0000_0001);

    // Directed: signed
    do_mult(1, 32'hFFFF_FFFD, 32'd5, "t3a");
    check("t3a_const", product[1], 64'hFFFF_FFFF_FFFF_FFF1);
    do_mult(1, 32'h8000_0000, 32'h8000_0000, "t3b");
    check("t3b_const", product[1], 64'h4000_0000_0000_0000);
    do_mult(1, 32'h8000_0000, 32'h0000_0001, "t3c");
    do_mult(0, 32'h0000_0000, 32'hDEAD_BEEF, "t3z");

    // Randomized against reference
    for (int i = 0; i < 8; i++) begin
      do_mult(0, $urandom, $urandom, "rnd_u");
      do_mult(1, $urandom, $urandom, "rnd_s");
    end

    // Backpressure with ignored in_valid
    out_ready[0] = 1'b0;
    start_op(0, 32'h0BAD_F00D, 32'h0000_1234, lat);
    wait_valid(0, lat);
    check("t4_lat", 64'(lat), 64'(W + 2));
    held = ref_mul(1'b0, 32'h0BAD_F00D, 32'h0000_1234);
    check("t4_prod", product[0], held);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'b1;
      mcand[0]    = $urandom;
      mplier[0]   = $urandom;
      tick;
      check("t4_hold_prod",  product[0],        held);
      check("t4_hold_valid", 64'(out_valid[0]), 64'd1);
      check("t4_hold_ready", 64'(in_ready[0]),  64'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick;
    check("t4_rel_ready", 64'(in_ready[0]),  64'd1);
    check("t4_rel_valid", 64'(out_valid[0]), 64'd0);
    tick;
    check("t4_no_start", 64'(busy[0]), 64'd0);
    check("t4_kept",     product[0],   held);

    // Asynchronous reset mid-CALC (count=15)
    start_op(0, 32'hCAFE_0001, 32'h7777_7777, lat);
    repeat (15) tick;
    #3 rst_n = 1'b0;
    #1;
    check("t5_valid",   64'(out_valid[0]), 64'd0);
    check("t5_product", product[0],        64'd0);
    check("t5_ready",   64'(in_ready[0]),  64'd1);
    check("t5_busy",    64'(busy[0]),      64'd0);
    #2 rst_n = 1'b1;
    tick;
    do_mult(0, 32'h1234_5678, 32'h0000_0010, "t5_after");
    check("t5_const", product[0], 64'h0000_0001_2345_6780);

    // Back-to-back with in_valid held high
    for (int i = 0; i < 3; i++) begin
      a6[i] = $urandom;
      b6[i] = $urandom;
    end
    sent = 0; got = 0; last_out = -1; cyc = 0;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    mcand[0]     = a6[0];
    mplier[0]    = b6[0];
    while (got < 3 && cyc < 400) begin
      acc = in_ready[0] && in_valid[0];
      tick;
      cyc++;
      if (acc) begin
        exp_q.push_back(ref_mul(1'b0, a6[sent], b6[sent]));
        sent++;
        if (sent < 3) begin
          mcand[0]  = a6[sent];
          mplier[0] = b6[sent];
        end else begin
          in_valid[0] = 1'b0;
        end
      end
      if (out_valid[0]) begin
        if (exp_q.size() == 0) check("t6_extra", 64'd1, 64'd0);
        else check("t6_prod", product[0], exp_q.pop_front());
        if (last_out >= 0) check("t6_gap", 64'(cyc - last_out), 64'(W + 3));
        last_out = cyc;
        got++;
      end
    end
    check("t6_count", 64'(got),  64'd3);
    check("t6_sent",  64'(sent), 64'd3);
    repeat (W + 4) begin
      tick;
      if (out_valid[0]) check("t6_dup", 64'd1, 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
